pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the LEGv8 fetch front end. It owns the PC register and drives sequential fetch addresses to instruction memory over a valid/ready handshake. It accepts branch redirects (B, CBZ, optional BR) from the execute stage and computes branch targets with the PC left-shifter at a fixed shift of 2. It signals a one-cycle redirect so the pipeline can flush wrong-path instructions.

## Interface
- ADDR_W, 64, PC and address width
- RESET_PC, 64'd0, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard stall; blocks sequential PC increment only
- fetch_ready  in  1  instruction memory accepts current pc
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  ADDR_W  current fetch address
- br_req  in  1  branch request; held until br_ack
- br_kind  in  2  00=B, 01=CBZ, 10=BR, 11=reserved
- br_base  in  ADDR_W  PC of the branch instruction
- br_offset  in  ADDR_W  sign-extended word offset
- br_zero  in  1  CBZ operand is zero, so the branch is taken
- br_reg  in  ADDR_W  BR register target
- br_ack  out  1  combinational; high in the cycle a request is accepted
- redirect  out  1  registered one-cycle pulse when pc loads a target

## Operation
- States: BOOT, FETCH, TARGET.
- Reset (async) puts the block in BOOT with pc=RESET_PC, fetch_valid=0, redirect=0, captured target cleared. br_ack=0 while reset is high.
- BOOT: one cycle, fetch_valid=0, then moves to FETCH.
- FETCH:
  - fetch_valid=1.
  - At each edge where fetch_valid & fetch_ready & !stall & no accepted branch: pc <= pc+4.
  - pc is held stable while fetch_ready=0 or stall=1.
- Branch accept: br_ack = br_req & (state==FETCH). Accepted requests, by kind:
  - B: tgt <= br_base + (br_offset<<2); go to TARGET.
  - CBZ, br_zero=1: same as B.
  - CBZ, br_zero=0: ack only, no TARGET. The sequential rule applies in that cycle.
  - BR: see Configuration.
  - 11: ack only, no effect.
- TARGET: fetch_valid=0. At the next edge pc <= tgt, state returns to FETCH, and redirect=1 for exactly one cycle.
- Arithmetic: all adds are modulo 2^ADDR_W (wrap, no flag). The shift discards bits shifted past ADDR_W-1.
- Branch acceptance wins over the sequential increment in the same cycle: pc is not incremented.
- A branch is accepted regardless of stall.
- A fetch that is pending when a branch is accepted is abandoned: fetch_valid drops in TARGET. Memory must tolerate withdrawn requests.
- br_req outside FETCH is not acked; the requester holds it.

## Timing
- Sequential throughput: one pc per cycle when fetch_ready=1 and stall=0.
- Redirect latency:
  - Accept edge E0.
  - TARGET cycle.
  - Target appears on pc, with fetch_valid=1 and redirect=1, after edge E1.
  - Result: exactly one bubble cycle.
- Not-taken CBZ: zero bubbles.
- Reset mid-TARGET discards the target. Outputs take reset values immediately, without waiting for a clock.

## Configuration
- PC_SEQ_BR_REG_EN defined:
  - BR behaves as a taken branch with tgt <= {br_reg[ADDR_W-1:2],2'b00}. The low bits are forced to zero and the shifter is bypassed.
  - Same TARGET timing and redirect pulse as B.
- PC_SEQ_BR_REG_EN undefined: BR is acked and ignored, identical to kind 11.

## Structure
- Package pc_seq_pkg contains:
  - state enum {BOOT, FETCH, TARGET}
  - BR_KIND_B/CBZ/BR/RSVD constants
  - PC_STEP=4
  - BR_SHIFT=3'd2
- One sub-module: the existing PC_Shifter, instantiated with shift_amount=BR_SHIFT to form br_offset<<2.
- The adder, the PC register and the FSM stay in pc_sequencer.

## Test plan
- Reset, fetch_ready=1, stall=0 -> one BOOT cycle (pc=0, fetch_valid=0), then pc=0x0,0x4,0x8,0xC on consecutive cycles.
- B with br_base=0x10, br_offset=5 -> br_ack high one cycle, one cycle fetch_valid=0, then pc=0x24 with redirect=1 for one cycle.
- CBZ br_zero=0 at pc=0x20 -> ack, no bubble, pc=0x24 next. CBZ br_zero=1, br_base=0x40, br_offset=-2 -> pc=0x38.
- stall=1 for 3 cycles at pc=0x8 -> pc holds 0x8. fetch_ready=0 likewise holds. B accepted during stall -> redirect still taken.
- Wrap: br_base=0xFFFF_FFFF_FFFF_FFFC, br_offset=1 -> pc=0x0. Sequential step from 0xFFFF_FFFF_FFFF_FFFC -> 0x0.
- Reset asserted in TARGET -> pc=0, fetch_valid=0, redirect=0 without a clock edge. BR with br_reg=0x1003 -> pc=0x1000 with macro; ack only, sequence unchanged without it.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
//
// Shared definitions for the LEGv8 fetch-front-end PC sequencer:
//   - state_e      : sequencer FSM states (BOOT, FETCH, TARGET)
//   - BR_KIND_*    : encodings of the br_kind request field
//   - PC_STEP      : sequential fetch increment in bytes
//   - BR_SHIFT     : word-to-byte shift applied to branch offsets
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        TARGET = 2'd2
    } state_e;

    localparam logic [1:0] BR_KIND_B    = 2'b00;
    localparam logic [1:0] BR_KIND_CBZ  = 2'b01;
    localparam logic [1:0] BR_KIND_BR   = 2'b10;
    localparam logic [1:0] BR_KIND_RSVD = 2'b11;

    localparam int unsigned PC_STEP  = 4;
    localparam logic [2:0]  BR_SHIFT = 3'd2;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_shifter.sv
// -----------------------------------------------------------------------------
// PC_Shifter
//
// Logical left shifter used to turn word offsets into byte offsets for branch
// target computation. Bits shifted past the MSB are discarded.
//
// Ports:
//   data_i        in  WIDTH  value to shift
//   shift_amount  in  3      left shift distance (0..7)
//   data_o        out WIDTH  data_i << shift_amount, truncated to WIDTH
// -----------------------------------------------------------------------------
module PC_Shifter #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       shift_amount,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = data_i << shift_amount;

endmodule : PC_Shifter

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the LEGv8 fetch front end. Owns the PC
// register, presents sequential fetch addresses to instruction memory over a
// valid/ready handshake, and accepts branch redirects from execute. A taken
// branch costs exactly one bubble cycle (TARGET) and produces a registered
// one-cycle redirect pulse when the target lands on pc.
//
// Configuration macro:
//   PC_SEQ_BR_REG_EN  when defined, BR (br_kind=2'b10) is a taken register
//                     branch to {br_reg[ADDR_W-1:2],2'b00}; when undefined,
//                     BR is acknowledged and otherwise ignored.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous active-high reset
//   stall        in   1       hazard stall, blocks sequential increment only
//   fetch_ready  in   1       instruction memory accepts current pc
//   fetch_valid  out  1       pc is a valid fetch request
//   pc           out  ADDR_W  current fetch address
//   br_req       in   1       branch request, held until br_ack
//   br_kind      in   2       00=B, 01=CBZ, 10=BR, 11=reserved
//   br_base      in   ADDR_W  PC of the branch instruction
//   br_offset    in   ADDR_W  sign-extended word offset
//   br_zero      in   1       CBZ operand is zero (branch taken)
//   br_reg       in   ADDR_W  BR register target
//   br_ack       out  1       combinational accept strobe
//   redirect     out  1       one-cycle pulse when pc loads a branch target
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              br_req,
    input  logic [1:0]        br_kind,
    input  logic [ADDR_W-1:0] br_base,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              br_zero,
    input  logic [ADDR_W-1:0] br_reg,
    output logic              br_ack,
    output logic              redirect
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              redirect_q, redirect_d;

    logic [ADDR_W-1:0] offset_bytes;
    logic [ADDR_W-1:0] br_target;
    logic              br_taken;
    logic              in_fetch;

    // Word offset to byte offset; overflow past the MSB is dropped.
    PC_Shifter #(
        .WIDTH (ADDR_W)
    ) u_shifter (
        .data_i       (br_offset),
        .shift_amount (BR_SHIFT),
        .data_o       (offset_bytes)
    );

`ifdef PC_SEQ_BR_REG_EN
    // Register targets are word aligned by construction; the low bits of
    // br_reg are deliberately ignored.
    logic unused_br_reg_lsbs;
    assign unused_br_reg_lsbs = ^br_reg[1:0];
`else
    logic unused_br_reg;
    assign unused_br_reg = ^br_reg;
`endif

    // Branch decode: whether the accepted request redirects, and where to.
    always_comb begin
        br_taken  = 1'b0;
        br_target = br_base + offset_bytes;
        unique case (br_kind)
            BR_KIND_B:    br_taken = 1'b1;
            BR_KIND_CBZ:  br_taken = br_zero;
            BR_KIND_BR: begin
`ifdef PC_SEQ_BR_REG_EN
                br_taken  = 1'b1;
                br_target = {br_reg[ADDR_W-1:2], 2'b00};
`else
                br_taken  = 1'b0;
`endif
            end
            BR_KIND_RSVD: br_taken = 1'b0;
            default:      br_taken = 1'b0;
        endcase
    end

    assign in_fetch    = (state_q == FETCH);
    assign fetch_valid = in_fetch;
    assign pc          = pc_q;
    assign redirect    = redirect_q;
    // Gated by reset so a request can never be acknowledged while the
    // sequencer is being reset, even in the delta before state_q settles.
    assign br_ack      = br_req & in_fetch & ~reset;

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        redirect_d = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (br_req && br_taken) begin
                    // Taken branch wins over the sequential step; any pending
                    // fetch is withdrawn in TARGET.
                    tgt_d   = br_target;
                    state_d = TARGET;
                end else if (fetch_ready && !stall) begin
                    // Not-taken and ignored kinds fall through to here so they
                    // cost no bubble.
                    pc_d = pc_q + ADDR_W'(PC_STEP);
                end
            end

            TARGET: begin
                pc_d       = tgt_q;
                state_d    = FETCH;
                redirect_d = 1'b1;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            redirect_q <= redirect_d;
        end
    end

endmodule : pc_sequencer
